// File: rtl/fpi_speed_ctl.sv
// FPI speed scheduler: picks fast/slow/refresh-stretch per PH0 cycle and tracks Disk II motors.
// All state advances only on ph0_en; outputs are registered and stable for a whole PH0 cycle.
module fpi_speed_ctl #(
  parameter logic [19:0] MOTOR_HOLD     = 20'd0,
  parameter logic [7:0]  REFRESH_PERIOD = 8'd9
) (
  input  logic        clk_14M,
  input  logic        reset_n,
  input  logic        ph0_en,
  input  logic        cpu_valid,
  input  logic        we,
  input  logic        IO,
  input  logic [7:0]  bank,
  input  logic [15:0] addr,
  input  logic [7:0]  cyareg,
  input  logic [7:0]  shadow,
  output logic        slow,
  output logic        slow_cycle,
  output logic        stretch,
  output logic [3:0]  motor_on,
  output logic [1:0]  mode_state
);

  typedef enum logic [1:0] {
    ST_FAST         = 2'd0,
    ST_SLOW         = 2'd1,
    ST_FAST_REFRESH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       refresh_cnt_q, refresh_cnt_d;
  logic [3:0]       motor_on_q, motor_on_d;
  logic [3:0][19:0] hold_cnt_q, hold_cnt_d;
  logic             slow_cycle_q, slow_cycle_d;

  logic       motor_acc;
  logic [1:0] motor_slot;
  logic       slow_req;
  logic       bank_lo;
  logic       shadow_hit;
  logic       slow_mem;
  logic       unused_bits;

  assign unused_bits = ^{cyareg[6:4], shadow[7:6], shadow[4:3]};

  // Slots C..F of the C0xx soft-switch page map onto motor index 0..3.
  assign motor_acc  = cpu_valid & IO & (addr[15:8] == 8'hC0) & (addr[7:4] >= 4'hC);
  assign motor_slot = addr[5:4];

  assign bank_lo    = (bank == 8'h00) | (bank == 8'h01);
  assign shadow_hit = (~shadow[0] & (addr >= 16'h0400) & (addr <= 16'h07FF))
                    | (~shadow[1] & (addr >= 16'h2000) & (addr <= 16'h3FFF))
                    | (~shadow[2] & (addr >= 16'h4000) & (addr <= 16'h5FFF))
                    | (~shadow[5] & (addr >= 16'h0800) & (addr <= 16'h0BFF));
  assign slow_mem   = (bank == 8'hE0) | (bank == 8'hE1)
                    | (bank_lo & (addr[15:12] == 4'hC))
                    | (bank_lo & we & shadow_hit);

  always_comb begin
    motor_on_d = motor_on_q;
    hold_cnt_d = hold_cnt_q;
    if (ph0_en) begin
      for (int n = 0; n < 4; n++) begin
        if (hold_cnt_q[n] != 20'd0) begin
          hold_cnt_d[n] = hold_cnt_q[n] - 20'd1;
          if (hold_cnt_q[n] == 20'd1) motor_on_d[n] = 1'b0;
        end
      end
      if (motor_acc) begin
        if (addr[3:0] == 4'h9) begin
          motor_on_d[motor_slot] = 1'b1;
          hold_cnt_d[motor_slot] = 20'd0;
        end else if ((addr[3:0] == 4'h8) && motor_on_q[motor_slot]) begin
          // A repeated off during a hold restarts the countdown.
          if (MOTOR_HOLD == 20'd0) begin
            motor_on_d[motor_slot] = 1'b0;
          end else begin
            motor_on_d[motor_slot] = 1'b1;
            hold_cnt_d[motor_slot] = MOTOR_HOLD;
          end
        end
      end
    end
  end

  // Uses the post-strobe motor state so slow drops on the same strobe the motor does.
  assign slow_req = ~cyareg[7] | (|(motor_on_d & cyareg[3:0]));

  always_comb begin
    state_d       = state_q;
    refresh_cnt_d = refresh_cnt_q;
    slow_cycle_d  = slow_cycle_q;
    if (ph0_en) begin
      case (state_q)
        ST_FAST: begin
          if (slow_req) begin
            state_d = ST_SLOW;
          end else if ((REFRESH_PERIOD != 8'd0) &&
                       (refresh_cnt_q == REFRESH_PERIOD - 8'd1)) begin
            state_d = ST_FAST_REFRESH;
          end else begin
            refresh_cnt_d = refresh_cnt_q + 8'd1;
          end
        end
        ST_FAST_REFRESH: begin
          refresh_cnt_d = 8'd0;
          state_d       = slow_req ? ST_SLOW : ST_FAST;
        end
        ST_SLOW: begin
          if (!slow_req) begin
            state_d       = ST_FAST;
            refresh_cnt_d = 8'd0;
          end
        end
        default: state_d = ST_FAST;
      endcase
      slow_cycle_d = (state_d == ST_SLOW) | (cpu_valid & slow_mem);
    end
  end

  always_ff @(posedge clk_14M) begin
    if (!reset_n) begin
      state_q       <= ST_FAST;
      refresh_cnt_q <= 8'd0;
      motor_on_q    <= 4'd0;
      hold_cnt_q    <= '0;
      slow_cycle_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      refresh_cnt_q <= refresh_cnt_d;
      motor_on_q    <= motor_on_d;
      hold_cnt_q    <= hold_cnt_d;
      slow_cycle_q  <= slow_cycle_d;
    end
  end

  assign slow       = (state_q == ST_SLOW);
  assign stretch    = (state_q == ST_FAST_REFRESH);
  assign slow_cycle = slow_cycle_q;
  assign motor_on   = motor_on_q;
  assign mode_state = state_q;

endmodule

// File: doc/fpi_speed_ctl.md
# fpi_speed_ctl

Speed scheduler for the IIgs FPI clock path. Sits between the CPU bus decode and `clock_divider`, and owns the decision whether each PH0 bus cycle runs fast or slow. It tracks Disk II motor state per slot (4–7), classifies each access as fast-capable or slow-only, and issues refresh stretch requests. Every decision is taken only at a PH0 cycle boundary, so the divider never sees a mid-cycle speed change.

## Interface
- `MOTOR_HOLD`, default 20'd0: PH0 cycles a slot's motor stays "on" after its motor-off access; 0 means immediate.
- `REFRESH_PERIOD`, default 8'd9: fast PH0 cycles between refresh stretches; 0 disables refresh.

Ports:
- `clk_14M` input, 1: 14.318 MHz system clock.
- `reset_n` input, 1: synchronous reset, active low.
- `ph0_en` input, 1: one-clock strobe from `clock_divider` marking a PH0 cycle boundary.
- `cpu_valid` input, 1: bus cycle present; sampled only when `ph0_en`=1.
- `we` input, 1: write cycle.
- `IO` input, 1: I/O space access.
- `bank` input, 8: CPU bank.
- `addr` input, 16: CPU address.
- `cyareg` input, 8: speed register. Bit 7 is fast; bits 3:0 are motor-detect enables for slots 7, 6, 5, 4.
- `shadow` input, 8: shadow register. A bit set to 1 inhibits that shadow region.
- `slow` output, 1: registered mode request to the divider.
- `slow_cycle` output, 1: the current bus cycle must run at 1 MHz.
- `stretch` output, 1: refresh stretch for the current bus cycle.
- `motor_on` output, 4: effective motor state for slots 7..4.
- `mode_state` output, 2: state code; 0 is FAST, 1 is SLOW, 2 is FAST_REFRESH.

## Operation
- **Motor decode.** A motor access is `cpu_valid & IO & addr[15:8]==8'hC0 & addr[7:4]>=4'hC`, with slot index = addr[7:4]−0xC.
  - addr[3:0]==8 is motor off.
  - addr[3:0]==9 is motor on.
  - Any other low nibble has no effect.
- **Per-slot motor tracking.** Each slot has a 20-bit hold counter.
  - Motor on: `motor_on[n]`←1 and the counter is cleared.
  - Motor off with `MOTOR_HOLD`=0: `motor_on[n]`←0 immediately.
  - Motor off otherwise: load the counter with `MOTOR_HOLD`. Decrement it on each `ph0_en`. When it reaches 1→0, clear `motor_on[n]`.
  - Motor on during a hold cancels the countdown; the bit stays 1.
  - Motor off while the bit is already 0 has no effect.
- **Mode request.** slow_req = ~cyareg[7] | |(motor_on & cyareg[3:0]).
- **Slow-memory classification.** The access is slow (`slow_mem`) if any of these holds:
  - bank E0 or E1, any address;
  - bank 00 or 01 and addr C000–CFFF;
  - bank 00 or 01, `we`=1, and an uninhibited shadow region is hit:
    - 0400–07FF when shadow[0]=0;
    - 2000–3FFF when shadow[1]=0;
    - 4000–5FFF when shadow[2]=0;
    - 0800–0BFF when shadow[5]=0.
- **State machine.** The FSM advances only on `ph0_en`.
  - FAST: if slow_req, go to SLOW. Otherwise, if the refresh counter equals `REFRESH_PERIOD`−1 and `REFRESH_PERIOD`≠0, go to FAST_REFRESH. Otherwise stay in FAST and increment the refresh counter.
  - FAST_REFRESH: go to SLOW if slow_req, else FAST. The refresh counter is cleared.
  - SLOW: if ~slow_req, go to FAST with the refresh counter cleared.
- **Outputs.**
  - `slow` = (state==SLOW).
  - `stretch` = (state==FAST_REFRESH).
  - `slow_cycle` = slow | (`cpu_valid` & slow_mem), registered at the `ph0_en` boundary. When `cpu_valid`=0, `slow_cycle` = `slow`.
- **Simultaneous events.** If slow_req becomes true on the same boundary that refresh would fire, SLOW wins and the refresh is dropped.

## Timing
- Reset values, with `reset_n`=0 on a `clk_14M` edge:
  - state FAST; `slow`=0, `stretch`=0, `slow_cycle`=0, `motor_on`=0;
  - hold and refresh counters 0.
- Reset asserted mid-cycle takes effect at the next edge and overrides any pending transition.
- Decisions are sampled on the edge where `ph0_en`=1. `slow`, `stretch`, `slow_cycle`, `mode_state` and `motor_on` update on that same edge, so they are visible one clock after the strobe and hold stable until the next `ph0_en`.
- A `cyareg` change between strobes has no effect until the next `ph0_en`. Worst-case latency to `slow` is one PH0 cycle plus one clock.
- `stretch` is high for exactly one PH0 cycle per refresh.
- There are no inputs other than `ph0_en` that advance the FSM; inputs between strobes are ignored, including by motor decode.

## Test plan
- **Mode switch.** `cyareg` 80 → 00 → 80, with ≥2 `ph0_en` between writes → `slow` goes 0→1 one clock after the first following strobe, then back to 0; `mode_state` reads 0, 1, 0.
- **Slot 6 motor.** `cyareg`=FF, access C0E9 on a strobe → `motor_on`=4'b0100 and `slow`=1. Access C0E8 with `MOTOR_HOLD`=3 → `motor_on[2]` clears on the 3rd following strobe and `slow`→0 at that same strobe. Repeat with `cyareg`=80 → `motor_on[2]`=1 but `slow` stays 0.
- **Hold cancel.** C0E8 then C0E9 two strobes later with `MOTOR_HOLD`=5 → `motor_on[2]` never drops.
- **Slow memory.** In FAST, check `slow_cycle` per access:
  - bank E1/0000 → 1;
  - bank 00/C123 → 1;
  - bank 02/C000 → 0;
  - bank 00/2000 write with shadow=00 → 1;
  - same write with shadow=02 → 0;
  - bank 00/2000 read → 0.
  `slow` stays 0 throughout.
- **Refresh.** `REFRESH_PERIOD`=9, FAST, `cpu_valid`=0 for 30 strobes → `stretch` is high for strobes 10, 20 and 30, one PH0 cycle each. Force slow_req on the strobe where refresh would fire → no stretch, state SLOW.
- **Reset.** Pulse `reset_n`=0 for one clock while in SLOW with a motor countdown active → all outputs 0, state FAST, and the countdown is discarded.
